// File: rtl/pll_div_pkg.sv
// Shared types and helpers for the PLL clock-divider bank.
package pll_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_t;

   localparam int unsigned DIV_MIN = 2;

   // Number of high cycles in a period of n input clocks (ceil(n/2)).
   function automatic int unsigned half_hi(input int unsigned n);
      return (n + 1) >> 1;
   endfunction

endpackage

// File: rtl/pll_div_ch.sv
// One divider channel: run/drain FSM, phase counter, shadowed ratio and status flags.
module pll_div_ch
   import pll_div_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned DIV_INIT = 2
) (
   input  logic             CLK_IN,
   input  logic             RESET_N,
   input  logic             LOCK,
   input  logic             SYNC,
   input  logic             CH_EN,
   input  logic             DIV_LOAD,
   input  logic [CNT_W-1:0] DIV_VAL,
   output logic             CLK_DIV,
   output logic             CE_PULSE,
   output logic             DIV_ACK,
   output logic             DIV_ERR
);

   ch_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active;
   logic [CNT_W-1:0] shadow;
   logic             pending;
   logic             last;
   logic             apply;
   logic             illegal;
   logic             hi_next;

   always_comb begin
      last    = (state != IDLE) && (cnt == active - CNT_W'(1));
      illegal = (DIV_VAL < CNT_W'(DIV_MIN));
      hi_next = (32'(cnt) + 32'd1) < half_hi(32'(active));
      apply   = pending && ((state == IDLE) ||
                            (LOCK && (last || (SYNC && state == RUN))));
   end

   always_ff @(posedge CLK_IN) begin
      if (!RESET_N) begin
         state    <= IDLE;
         cnt      <= '0;
         active   <= CNT_W'(DIV_INIT);
         shadow   <= CNT_W'(DIV_INIT);
         pending  <= 1'b0;
         CLK_DIV  <= 1'b0;
         CE_PULSE <= 1'b0;
         DIV_ACK  <= 1'b0;
         DIV_ERR  <= 1'b0;
      end else begin
         CE_PULSE <= 1'b0;
         DIV_ACK  <= 1'b0;
         if (!LOCK) begin
            state   <= IDLE;
            cnt     <= '0;
            CLK_DIV <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (CH_EN) begin
                     state    <= RUN;
                     cnt      <= '0;
                     CLK_DIV  <= 1'b1;
                     CE_PULSE <= 1'b1;
                  end
               end
               RUN: begin
                  if (SYNC || (last && CH_EN)) begin
                     cnt      <= '0;
                     CLK_DIV  <= 1'b1;
                     CE_PULSE <= 1'b1;
                  // enable dropped on the final count: the period is already complete
                  end else if (last) begin
                     state   <= IDLE;
                     cnt     <= '0;
                     CLK_DIV <= 1'b0;
                  end else begin
                     cnt     <= cnt + CNT_W'(1);
                     CLK_DIV <= hi_next;
                     if (!CH_EN) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (last) begin
                     state   <= IDLE;
                     cnt     <= '0;
                     CLK_DIV <= 1'b0;
                  end else begin
                     cnt     <= cnt + CNT_W'(1);
                     CLK_DIV <= hi_next;
                  end
               end
               default: state <= IDLE;
            endcase
         end
         // a load in the apply cycle overrides the pending clear, so it waits for the next wrap
         if (apply) begin
            active  <= shadow;
            pending <= 1'b0;
            DIV_ACK <= 1'b1;
         end
         if (DIV_LOAD) begin
            shadow  <= illegal ? CNT_W'(DIV_MIN) : DIV_VAL;
            pending <= 1'b1;
            if (illegal) DIV_ERR <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers sharing LOCK and SYNC.
module pll_clk_div_bank
   import pll_div_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned DIV_INIT = 2
) (
   input  logic                    CLK_IN,
   input  logic                    RESET_N,
   input  logic                    LOCK,
   input  logic                    SYNC,
   input  logic [NUM_CH-1:0]       CH_EN,
   input  logic [NUM_CH-1:0]       DIV_LOAD,
   input  logic [NUM_CH*CNT_W-1:0] DIV_VAL,
   output logic [NUM_CH-1:0]       CLK_DIV,
   output logic [NUM_CH-1:0]       CE_PULSE,
   output logic [NUM_CH-1:0]       DIV_ACK,
   output logic [NUM_CH-1:0]       DIV_ERR
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pll_div_ch #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_ch (
         .CLK_IN   (CLK_IN),
         .RESET_N  (RESET_N),
         .LOCK     (LOCK),
         .SYNC     (SYNC),
         .CH_EN    (CH_EN[i]),
         .DIV_LOAD (DIV_LOAD[i]),
         .DIV_VAL  (DIV_VAL[i*CNT_W +: CNT_W]),
         .CLK_DIV  (CLK_DIV[i]),
         .CE_PULSE (CE_PULSE[i]),
         .DIV_ACK  (DIV_ACK[i]),
         .DIV_ERR  (DIV_ERR[i])
      );
   end

endmodule
